// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Cycle-based front end for a 3-bit-command ALU. Accepts one operation at a
// time over a valid/ready request port, launches the command and operands to
// the ALU from registers, waits a fixed settle interval, then captures the
// ALU result and status into a response register. The response is held under
// a valid/ready handshake.
//
// Parameters
//   WIDTH   operand/result width
//   SETTLE  cycles from operand launch to result capture (1..255)
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid_i    request present
//   req_ready_o    sequencer can accept (IDLE only)
//   req_cmd_i      ALU command (000 add .. 111 or)
//   req_a_i/b_i    operands
//   alu_cmd_o      registered command to the ALU
//   alu_a_o/b_o    registered operands to the ALU
//   alu_result_i   ALU result
//   alu_cout_i     ALU carry
//   alu_flag_i     ALU overflow
//   alu_zero_i     ALU zero
//   rsp_valid_o    response present
//   rsp_ready_i    consumer accepts response
//   rsp_result_o   captured result
//   rsp_cout_o/rsp_flag_o/rsp_zero_o  captured status
//   busy_o         high whenever the sequencer is not idle
//
// Optional feature, enabled by defining ALU_STICKY_STATUS_EN:
//   sticky_clr_i   synchronous clear of the sticky status bits
//   sticky_cout_o  OR of carry over all captured add/sub operations
//   sticky_flag_o  OR of overflow over all captured add/sub operations
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_cmd_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic [2:0]       alu_cmd_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_cout_i,
    input  logic             alu_flag_i,
    input  logic             alu_zero_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_cout_o,
    output logic             rsp_flag_o,
    output logic             rsp_zero_o,
`ifdef ALU_STICKY_STATUS_EN
    input  logic             sticky_clr_i,
    output logic             sticky_cout_o,
    output logic             sticky_flag_o,
`endif
    output logic             busy_o
);

    // The settle counter is 8 bits; anything outside 1..255 cannot be timed.
    generate
        if ((SETTLE < 1) || (SETTLE > 255)) begin : g_settle_range_check
            $error("alu_sequencer: SETTLE must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Add and subtract are the only commands whose carry/overflow are tracked.
    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd[2:1] == 2'b00);
    endfunction

    state_e           state_q,      state_d;
    logic [7:0]       cnt_q,        cnt_d;
    logic [2:0]       alu_cmd_q,    alu_cmd_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_cout_q,   rsp_cout_d;
    logic             rsp_flag_q,   rsp_flag_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             req_ready_q,  req_ready_d;
    logic             busy_q,       busy_d;
    logic             capture_s;

    // Next-state, launch-register and capture-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_cmd_d    = alu_cmd_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_zero_d   = rsp_zero_q;
        capture_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    alu_cmd_d = req_cmd_i;
                    alu_a_d   = req_a_i;
                    alu_b_d   = req_b_i;
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    capture_s    = 1'b1;
                    rsp_result_d = alu_result_i;
                    rsp_cout_d   = alu_cout_i;
                    rsp_flag_d   = alu_flag_i;
                    rsp_zero_d   = alu_zero_i;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE without a response.
                state_d     = ST_IDLE;
                cnt_d       = 8'd0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // Handshake/status outputs are registered from the next state so they
        // change on the same edge as the state itself.
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counter, launch and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            alu_cmd_q    <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_flag_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_cmd_q    <= alu_cmd_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_zero_q   <= rsp_zero_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ALU_STICKY_STATUS_EN
    logic sticky_cout_q, sticky_cout_d;
    logic sticky_flag_q, sticky_flag_d;
    logic sticky_base_cout_s;
    logic sticky_base_flag_s;

    // Sticky status: clear first, then OR in an add/sub capture on the same
    // edge so a simultaneous capture ends at the new event's value.
    always_comb begin
        sticky_base_cout_s = sticky_clr_i ? 1'b0 : sticky_cout_q;
        sticky_base_flag_s = sticky_clr_i ? 1'b0 : sticky_flag_q;
        if (capture_s && is_arith(alu_cmd_q)) begin
            sticky_cout_d = sticky_base_cout_s | alu_cout_i;
            sticky_flag_d = sticky_base_flag_s | alu_flag_i;
        end else begin
            sticky_cout_d = sticky_base_cout_s;
            sticky_flag_d = sticky_base_flag_s;
        end
    end

    // Sticky status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_cout_q <= 1'b0;
            sticky_flag_q <= 1'b0;
        end else begin
            sticky_cout_q <= sticky_cout_d;
            sticky_flag_q <= sticky_flag_d;
        end
    end

    assign sticky_cout_o = sticky_cout_q;
    assign sticky_flag_o = sticky_flag_q;
`else
    logic unused_capture_s;
    assign unused_capture_s = capture_s & is_arith(alu_cmd_q);
`endif

    assign req_ready_o  = req_ready_q;
    assign busy_o       = busy_q;
    assign alu_cmd_o    = alu_cmd_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_cout_o   = rsp_cout_q;
    assign rsp_flag_o   = rsp_flag_q;
    assign rsp_zero_o   = rsp_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. The bench plays the ALU: it computes
// each command arithmetically, but presents inverted (wrong) values until the
// operands have been stable long enough for the configured settle interval,
// so an early capture shows up as a wrong response. Expected responses come
// from the requested operands, never from the DUT's launch registers.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_cmd_i;
    logic [WIDTH-1:0] req_a_i;
    logic [WIDTH-1:0] req_b_i;
    logic [2:0]       alu_cmd_o;
    logic [WIDTH-1:0] alu_a_o;
    logic [WIDTH-1:0] alu_b_o;
    logic [WIDTH-1:0] alu_result_i;
    logic             alu_cout_i;
    logic             alu_flag_i;
    logic             alu_zero_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] rsp_result_o;
    logic             rsp_cout_o;
    logic             rsp_flag_o;
    logic             rsp_zero_o;
    logic             busy_o;
`ifdef ALU_STICKY_STATUS_EN
    logic             sticky_clr_i;
    logic             sticky_cout_o;
    logic             sticky_flag_o;
    bit               sm_cout = 1'b0;
    bit               sm_flag = 1'b0;
`endif

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint cur_accept = 0;
    longint last_accept = 0;
    int     age = 255;
    logic [2:0]  nxt_cmd;
    logic [31:0] nxt_a;
    logic [31:0] nxt_b;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_cmd_i    (req_cmd_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .alu_cmd_o    (alu_cmd_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .alu_cout_i   (alu_cout_i),
        .alu_flag_i   (alu_flag_i),
        .alu_zero_i   (alu_zero_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_cout_o   (rsp_cout_o),
        .rsp_flag_o   (rsp_flag_o),
        .rsp_zero_o   (rsp_zero_o),
`ifdef ALU_STICKY_STATUS_EN
        .sticky_clr_i (sticky_clr_i),
        .sticky_cout_o(sticky_cout_o),
        .sticky_flag_o(sticky_flag_o),
`endif
        .busy_o       (busy_o)
    );

    // Reference ALU: {result, cout, overflow, zero}.
    function automatic logic [34:0] ref_alu(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (cmd)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2:    r = a ^ b;
            3'd3:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    r = a & b;
            3'd5:    r = ~(a & b);
            3'd6:    r = ~(a | b);
            default: r = a | b;
        endcase
        return {r, c, v, (r == 32'd0)};
    endfunction

    // Cycles since the last accepted request (operands launched).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid_i && req_ready_o) age <= 0;
        else if (age < 255) age <= age + 1;
    end

    // Bench ALU: correct only once settled.
    always_comb begin
        logic [34:0] t;
        t = ref_alu(alu_cmd_o, alu_a_o, alu_b_o);
        if (age < SETTLE - 1) t = ~t;
        {alu_result_i, alu_cout_i, alu_flag_i, alu_zero_i} = t;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; hold = cycles of response backpressure, keep_valid
    // presents the nxt_* request during backpressure, clr_cap pulses the
    // sticky clear on the capture edge.
    task automatic do_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit keep_valid, input bit clr_cap);
        int n;
        logic [34:0] e;
        e = ref_alu(cmd, a, b);
        req_cmd_i   = cmd;
        req_a_i     = a;
        req_b_i     = b;
        req_valid_i = 1'b1;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 100), 64'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        last_accept = cur_accept;
        cur_accept  = cyc;
        if (hold > 0) rsp_ready_i = 1'b0;
        check("launch_cmd", 64'(alu_cmd_o), 64'(cmd));
        check("launch_a", 64'(alu_a_o), 64'(a));
        check("launch_b", 64'(alu_b_o), 64'(b));
        check("busy_settle", 64'(busy_o), 64'd1);
        check("ready_settle", 64'(req_ready_o), 64'd0);
        for (int k = 1; k <= SETTLE; k++) begin
`ifdef ALU_STICKY_STATUS_EN
            if (k == SETTLE && clr_cap) sticky_clr_i = 1'b1;
`endif
            @(negedge clk);
`ifdef ALU_STICKY_STATUS_EN
            sticky_clr_i = 1'b0;
`endif
            if (k < SETTLE) begin
                check("early_valid", 64'(rsp_valid_o), 64'd0);
                check("settle_a_stable", 64'(alu_a_o), 64'(a));
                check("settle_b_stable", 64'(alu_b_o), 64'(b));
            end
        end
        check("rsp_valid_latency", 64'(rsp_valid_o), 64'd1);
        check("rsp_result", 64'(rsp_result_o), 64'(e[34:3]));
        check("rsp_cout", 64'(rsp_cout_o), 64'(e[2]));
        check("rsp_flag", 64'(rsp_flag_o), 64'(e[1]));
        check("rsp_zero", 64'(rsp_zero_o), 64'(e[0]));
`ifdef ALU_STICKY_STATUS_EN
        if (clr_cap) begin
            sm_cout = 1'b0;
            sm_flag = 1'b0;
        end
        if (cmd == 3'd0 || cmd == 3'd1) begin
            sm_cout = sm_cout | e[2];
            sm_flag = sm_flag | e[1];
        end
        check("sticky_cout", 64'(sticky_cout_o), 64'(sm_cout));
        check("sticky_flag", 64'(sticky_flag_o), 64'(sm_flag));
`else
        if (clr_cap) n = 0;
`endif
        for (int h = 0; h < hold; h++) begin
            if (keep_valid) begin
                req_cmd_i   = nxt_cmd;
                req_a_i     = nxt_a;
                req_b_i     = nxt_b;
                req_valid_i = 1'b1;
            end
            @(negedge clk);
            check("bp_valid", 64'(rsp_valid_o), 64'd1);
            check("bp_result", 64'(rsp_result_o), 64'(e[34:3]));
            check("bp_ready", 64'(req_ready_o), 64'd0);
            check("bp_busy", 64'(busy_o), 64'd1);
            check("bp_alu_a", 64'(alu_a_o), 64'(a));
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        check("post_hs_valid", 64'(rsp_valid_o), 64'd0);
        check("post_hs_ready", 64'(req_ready_o), 64'd1);
        check("post_hs_busy", 64'(busy_o), 64'd0);
        check("post_hs_retain", 64'(rsp_result_o), 64'(e[34:3]));
    endtask

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_cmd_i   = 3'd0;
        req_a_i     = 32'd0;
        req_b_i     = 32'd0;
        rsp_ready_i = 1'b1;
        nxt_cmd     = 3'd0;
        nxt_a       = 32'd0;
        nxt_b       = 32'd0;
`ifdef ALU_STICKY_STATUS_EN
        sticky_clr_i = 1'b0;
`endif
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_alu_a", 64'(alu_a_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_result", 64'(rsp_result_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);

        // ADD 5+7.
        do_op(3'd0, 32'd5, 32'd7, 0, 1'b0, 1'b0);
        check("add_5_7", 64'(rsp_result_o), 64'd12);

        // SUB 3-3 then ADD 0xFFFFFFFF+1 back to back.
        do_op(3'd1, 32'd3, 32'd3, 0, 1'b0, 1'b0);
        check("sub_zero", 64'(rsp_zero_o), 64'd1);
        do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
        check("add_wrap_cout", 64'(rsp_cout_o), 64'd1);
        check("add_wrap_zero", 64'(rsp_zero_o), 64'd1);
        check("throughput", 64'(cur_accept - last_accept), 64'(SETTLE + 2));

        // SLT -2 < 1.
        do_op(3'd3, 32'hFFFF_FFFE, 32'd1, 0, 1'b0, 1'b0);
        check("slt_neg", 64'(rsp_result_o), 64'd1);

        // Backpressure with a pending request.
        nxt_cmd = 3'd2;
        nxt_a   = 32'h0000_1234;
        nxt_b   = 32'h0000_5678;
        do_op(3'd4, 32'h0000_F0F0, 32'h0000_0FF0, 10, 1'b1, 1'b0);
        check("and_bp_result", 64'(rsp_result_o), 64'h00F0);
        do_op(nxt_cmd, nxt_a, nxt_b, 0, 1'b0, 1'b0);
        check("pending_accept_gap", 64'(cur_accept - last_accept), 64'(SETTLE + 2 + 10));

        // Reset during SETTLE of an OR.
        req_cmd_i   = 3'd7;
        req_a_i     = 32'hA5A5_0000;
        req_b_i     = 32'h0000_5A5A;
        req_valid_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        check("or_in_settle", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_cmd", 64'(alu_cmd_o), 64'd0);
        check("mid_rst_alu_a", 64'(alu_a_o), 64'd0);
        check("mid_rst_alu_b", 64'(alu_b_o), 64'd0);
        check("mid_rst_rsp_result", 64'(rsp_result_o), 64'd0);
        check("mid_rst_rsp_status", 64'({rsp_valid_o, rsp_cout_o, rsp_flag_o, rsp_zero_o}), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef ALU_STICKY_STATUS_EN
        sm_cout = 1'b0;
        sm_flag = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 64'({rsp_valid_o, busy_o}), 64'd0);
        end
        do_op(3'd7, 32'hA5A5_0000, 32'h0000_5A5A, 1, 1'b0, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 25; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            do_op(rc, ra, rb, int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

`ifdef ALU_STICKY_STATUS_EN
        // Sticky status.
        sticky_clr_i = 1'b1;
        @(negedge clk);
        sticky_clr_i = 1'b0;
        sm_cout = 1'b0;
        sm_flag = 1'b0;
        do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
        check("sticky_ovf_set", 64'(sticky_flag_o), 64'd1);
        do_op(3'd2, 32'h1234_5678, 32'h1111_1111, 0, 1'b0, 1'b0);
        check("sticky_xor_hold", 64'(sticky_flag_o), 64'd1);
        sticky_clr_i = 1'b1;
        @(negedge clk);
        sticky_clr_i = 1'b0;
        sm_cout = 1'b0;
        sm_flag = 1'b0;
        check("sticky_clr_alone", 64'({sticky_cout_o, sticky_flag_o}), 64'd0);
        do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, 1'b1);
        check("sticky_clr_vs_capture", 64'(sticky_flag_o), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
